// File: rtl/ecp_pll_phase_ctrl.sv
// ecp_pll_phase_ctrl
//
// Bring-up and dynamic phase-shift sequencer for an ECP5 EHXPLLL. Runs in the
// PLL reference clock domain, holds the PLL in reset, waits for lock (retrying
// on timeout) and then executes phase-shift commands by driving PHASESEL,
// PHASEDIR and low pulses on PHASESTEP. Every output is a flop.
//
// Ports
//   clk         reference clock (PLL CLKI domain)
//   resetn      asynchronous active-low reset
//   pll_locked  PLL LOCK pin (asynchronous, synchronised internally)
//   cmd_valid   phase-shift command valid
//   cmd_ready   high only while idle; command accepted on valid & ready
//   cmd_sel     output to shift (0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3)
//   cmd_dir     phase direction, forwarded to PHASEDIR
//   cmd_steps   number of phase steps (unsigned)
//   done        one-cycle pulse when a command finishes or aborts
//   err         one-cycle pulse with done when a command aborts on lock loss
//   pll_rst     PLL RST, active high
//   phasesel    PHASESEL[1:0]
//   phasedir    PHASEDIR
//   phasestep   PHASESTEP; idles high, one step = one low pulse
//   pll_ready   synchronised lock and sequencer idle
module ecp_pll_phase_ctrl #(
    parameter int unsigned STEP_W       = 8,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pll_locked,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_sel,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    output logic              done,
    output logic              err,
    output logic              pll_rst,
    output logic [1:0]        phasesel,
    output logic              phasedir,
    output logic              phasestep,
    output logic              pll_ready
);

    // One shared phase counter serves every timed state; size it for the longest.
    localparam int unsigned Max01  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned Max23  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned Max0123 = (Max01 > Max23) ? Max01 : Max23;
    localparam int unsigned CntMax = (Max0123 > GAP_CYCLES) ? Max0123 : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] RstLast   = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0] LockLast  = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0] SetupLast = CntW'(SETUP_CYCLES - 1);
    localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast   = CntW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StRst,
        StWlock,
        StIdle,
        StSetup,
        StPulse,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              lock_meta_q, lock_s_q;
    logic              pll_rst_q, pll_rst_d;
    logic              phasestep_q, phasestep_d;
    logic [1:0]        phasesel_q, phasesel_d;
    logic              phasedir_q, phasedir_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              pll_ready_q, pll_ready_d;

    // Two-flop synchroniser for the asynchronous LOCK pin.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CntW'(1);
        rem_d       = rem_q;
        phasesel_d  = phasesel_q;
        phasedir_d  = phasedir_q;
        pll_rst_d   = 1'b0;
        phasestep_d = 1'b1;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            StRst: begin
                pll_rst_d = 1'b1;
                if (cnt_q == RstLast) begin
                    state_d   = StWlock;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end
            end

            StWlock: begin
                if (lock_s_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == LockLast) begin
                    state_d   = StRst;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                end
            end

            StIdle: begin
                cnt_d = '0;
                if (cmd_valid) begin
                    // cmd_ready is high here, so the command is accepted no matter what.
                    phasesel_d = cmd_sel;
                    phasedir_d = cmd_dir;
                    rem_d      = cmd_steps;
                    if (!lock_s_q) begin
                        // Lock lost in the acceptance cycle: close the command at once so
                        // every accepted command still sees exactly one done.
                        state_d   = StRst;
                        pll_rst_d = 1'b1;
                        done_d    = 1'b1;
                        err_d     = (cmd_steps != '0);
                    end else if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StSetup;
                    end
                end else if (!lock_s_q) begin
                    state_d   = StRst;
                    pll_rst_d = 1'b1;
                end
            end

            StSetup, StPulse, StGap: begin
                if (!lock_s_q) begin
                    // Abort: steps already issued stay applied inside the PLL.
                    state_d   = StRst;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                end else if (state_q == StSetup) begin
                    if (cnt_q == SetupLast) begin
                        state_d     = StPulse;
                        cnt_d       = '0;
                        phasestep_d = 1'b0;
                    end
                end else if (state_q == StPulse) begin
                    phasestep_d = 1'b0;
                    if (cnt_q == PulseLast) begin
                        state_d     = StGap;
                        cnt_d       = '0;
                        rem_d       = rem_q - STEP_W'(1);
                        phasestep_d = 1'b1;
                    end
                end else begin
                    if (cnt_q == GapLast) begin
                        cnt_d = '0;
                        if (rem_q != '0) begin
                            state_d     = StPulse;
                            phasestep_d = 1'b0;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d   = StRst;
                cnt_d     = '0;
                pll_rst_d = 1'b1;
            end
        endcase

        // Idle can only be entered or held with lock_s high, so both flags track state_d.
        cmd_ready_d = (state_d == StIdle);
        pll_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StRst;
            cnt_q       <= '0;
            rem_q       <= '0;
            pll_rst_q   <= 1'b1;
            phasestep_q <= 1'b1;
            phasesel_q  <= 2'd0;
            phasedir_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            pll_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            pll_rst_q   <= pll_rst_d;
            phasestep_q <= phasestep_d;
            phasesel_q  <= phasesel_d;
            phasedir_q  <= phasedir_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            pll_ready_q <= pll_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign pll_rst   = pll_rst_q;
    assign phasesel  = phasesel_q;
    assign phasedir  = phasedir_q;
    assign phasestep = phasestep_q;
    assign pll_ready = pll_ready_q;

endmodule

// File: tb/tb_ecp_pll_phase_ctrl.sv
// Directed bench for ecp_pll_phase_ctrl with default parameters.
// Outputs are sampled on the falling clock edge; "cycle k" is the sample taken
// after the k-th rising edge following reset release or command acceptance.
module tb_ecp_pll_phase_ctrl;

    logic       clk;
    logic       resetn;
    logic       pll_locked;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_sel;
    logic       cmd_dir;
    logic [7:0] cmd_steps;
    logic       done;
    logic       err;
    logic       pll_rst;
    logic [1:0] phasesel;
    logic       phasedir;
    logic       phasestep;
    logic       pll_ready;

    int n_checks;
    int n_fail;

    ecp_pll_phase_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .pll_locked (pll_locked),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sel    (cmd_sel),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .done       (done),
        .err        (err),
        .pll_rst    (pll_rst),
        .phasesel   (phasesel),
        .phasedir   (phasedir),
        .phasestep  (phasestep),
        .pll_ready  (pll_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        chk({tag, "_phasestep"}, 32'(phasestep), 32'd1);
        chk({tag, "_phasedir"}, 32'(phasedir), 32'd0);
        chk({tag, "_phasesel"}, 32'(phasesel), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_pll_ready"}, 32'(pll_ready), 32'd0);
    endtask

    initial begin
        logic [31:0] stp;
        logic [31:0] dn;
        logic [31:0] rdy;
        logic [31:0] exp_stp;
        logic        seen;
        logic        prev;
        int          falls;

        n_checks   = 0;
        n_fail     = 0;
        resetn     = 1'b0;
        pll_locked = 1'b0;
        cmd_valid  = 1'b0;
        cmd_sel    = 2'd0;
        cmd_dir    = 1'b0;
        cmd_steps  = 8'd0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk_reset_values("reset");

        // No lock ever: pll_rst low at cycle 16, re-asserted at 16+4096, low again 16 later.
        resetn = 1'b1;
        seen   = 1'b0;
        repeat (15) @(negedge clk);
        chk("nolock_rst_hold", 32'(pll_rst), 32'd1);
        @(negedge clk);
        chk("nolock_rst_release", 32'(pll_rst), 32'd0);
        for (int k = 17; k <= 4111; k++) begin
            @(negedge clk);
            seen = seen | pll_ready | pll_rst;
        end
        chk("nolock_wait_quiet", 32'(seen), 32'd0);
        @(negedge clk);
        chk("nolock_retry_rst", 32'(pll_rst), 32'd1);
        repeat (15) @(negedge clk);
        chk("nolock_retry_hold", 32'(pll_rst), 32'd1);
        @(negedge clk);
        chk("nolock_retry_release", 32'(pll_rst), 32'd0);
        chk("nolock_pll_ready", 32'(pll_ready), 32'd0);

        // Fresh bring-up with lock arriving at cycle 30; ready at cycle 33.
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 15) chk("up_rst_hold", 32'(pll_rst), 32'd1);
            if (k == 16) chk("up_rst_release", 32'(pll_rst), 32'd0);
            if (k == 32) chk("up_not_ready_yet", 32'(pll_ready), 32'd0);
            if (k == 33) begin
                chk("up_pll_ready", 32'(pll_ready), 32'd1);
                chk("up_cmd_ready", 32'(cmd_ready), 32'd1);
            end
            if (k == 30) pll_locked = 1'b1;
        end

        // Command sel=2 dir=1 steps=3: pulses low at 3-4, 9-10, 15-16; done at 21.
        cmd_valid = 1'b1;
        cmd_sel   = 2'd2;
        cmd_dir   = 1'b1;
        cmd_steps = 8'd3;
        stp       = 32'hFFFF_FFFF;
        dn        = 32'h0;
        seen      = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("c3_phasesel", 32'(phasesel), 32'd2);
                chk("c3_phasedir", 32'(phasedir), 32'd1);
                chk("c3_busy", 32'(cmd_ready), 32'd0);
                cmd_valid = 1'b0;
                cmd_sel   = 2'd0;
                cmd_dir   = 1'b0;
            end
            stp[c] = phasestep;
            dn[c]  = done;
            seen   = seen | err;
            if (c == 21) chk("c3_ready_at_done", 32'(cmd_ready), 32'd1);
        end
        exp_stp = 32'hFFFF_FFFF;
        exp_stp[3] = 1'b0;  exp_stp[4] = 1'b0;
        exp_stp[9] = 1'b0;  exp_stp[10] = 1'b0;
        exp_stp[15] = 1'b0; exp_stp[16] = 1'b0;
        chk("c3_phasestep_trace", stp, exp_stp);
        chk("c3_done_trace", dn, 32'h0020_0000);
        chk("c3_err", 32'(seen), 32'd0);
        chk("c3_sel_held", 32'(phasesel), 32'd2);

        // Zero steps: done one cycle after accept, ready stays high, no stepping.
        cmd_valid = 1'b1;
        cmd_sel   = 2'd1;
        cmd_dir   = 1'b0;
        cmd_steps = 8'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("z_done", 32'(done), 32'd1);
        chk("z_err", 32'(err), 32'd0);
        chk("z_ready", 32'(cmd_ready), 32'd1);
        chk("z_phasesel", 32'(phasesel), 32'd1);
        chk("z_phasestep", 32'(phasestep), 32'd1);
        @(negedge clk);
        chk("z_done_clear", 32'(done), 32'd0);

        // Back-to-back, cmd_valid held: steps=1 finishes at 9, second accepted there, done 18.
        cmd_valid = 1'b1;
        cmd_steps = 8'd1;
        dn        = 32'h0;
        rdy       = 32'h0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            dn[c]  = done;
            rdy[c] = cmd_ready;
            if (c == 10) cmd_valid = 1'b0;
        end
        chk("b2b_done_trace", dn, 32'h0004_0200);
        chk("b2b_ready_trace", rdy, 32'h0004_0200);

        // Steps=200, lock pin drops after the 50th pulse starts (cycle 297): abort at 300.
        cmd_valid = 1'b1;
        cmd_sel   = 2'd3;
        cmd_dir   = 1'b1;
        cmd_steps = 8'd200;
        falls     = 0;
        prev      = 1'b1;
        seen      = 1'b0;
        for (int c = 1; c <= 317; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            if (prev && !phasestep) falls++;
            prev = phasestep;
            if (c < 300) seen = seen | done | err;
            if (c == 300) begin
                chk("abort_done", 32'(done), 32'd1);
                chk("abort_err", 32'(err), 32'd1);
                chk("abort_phasestep", 32'(phasestep), 32'd1);
                chk("abort_pll_rst", 32'(pll_rst), 32'd1);
                chk("abort_ready", 32'(cmd_ready), 32'd0);
                chk("abort_pulses", 32'(falls), 32'd50);
                chk("abort_no_early_done", 32'(seen), 32'd0);
            end
            if (c == 301) chk("abort_done_clear", 32'(done | err), 32'd0);
            if (c == 316) chk("relock_not_yet", 32'(pll_ready), 32'd0);
            if (c == 317) chk("relock_ready", 32'(pll_ready), 32'd1);
            if (c == 297) pll_locked = 1'b0;
            if (c == 305) pll_locked = 1'b1;
        end
        chk("abort_no_extra_pulse", 32'(falls), 32'd50);

        // resetn pulsed mid-command (cycle 4 is inside the first low pulse).
        cmd_valid = 1'b1;
        cmd_sel   = 2'd2;
        cmd_dir   = 1'b1;
        cmd_steps = 8'd5;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
        end
        chk("mid_pulse_low", 32'(phasestep), 32'd0);
        resetn = 1'b0;
        #1;
        chk_reset_values("async_rst");
        @(negedge clk);
        resetn = 1'b1;
        seen   = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            seen = seen | done | err;
            if (k == 16) chk("rerst_not_ready", 32'(pll_ready), 32'd0);
            if (k == 17) chk("rerst_ready", 32'(pll_ready), 32'd1);
        end
        chk("rerst_no_done", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
